// File: rtl/hms_time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : hms_time_keeper
// Description : 24-hour HH:MM:SS timekeeper with six BCD digits, a one-second
//               prescaler, and a push-button set mode (hours, then minutes)
//               with a blinking blank mask for the field being edited.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               en         - run enable (freezes timekeeping in RUN when 0)
//               btn_mode   - debounced level, rising edge cycles mode
//               btn_inc    - debounced level, rising edge increments field
//               time_bcd   - {hr_t,hr_u,min_t,min_u,sec_t,sec_u}, BCD
//               blank_mask - 1 = digit blanked, bit5 = hr_t
//               mode       - 0 RUN, 1 SET_HR, 2 SET_MIN
//               sec_tick   - one-cycle pulse with each seconds advance
// Revision    : 1.0 - initial release
// ============================================================================
module hms_time_keeper #(
    parameter int TICK_COUNT = 100000000,
    parameter int PW         = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [23:0] time_bcd,
    output logic [5:0]  blank_mask,
    output logic [1:0]  mode,
    output logic        sec_tick
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    localparam logic [PW-1:0] c_presc_last = PW'(TICK_COUNT - 1);
    localparam logic [PW-1:0] c_presc_half = PW'(TICK_COUNT / 2 - 1);

    // Registered state
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_blink;
    logic [3:0]    r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u;
    logic          r_mode_q, r_inc_q;
    logic [5:0]    r_blank;
    logic          r_tick;

    // Next-state values
    state_t        w_state;
    logic [PW-1:0] w_presc;
    logic          w_blink;
    logic [3:0]    w_hr_t, w_hr_u, w_min_t, w_min_u, w_sec_t, w_sec_u;
    logic [5:0]    w_blank;
    logic          w_tick;

    logic          w_mode_edge, w_inc_edge, w_wrap, w_half;
    logic [PW-1:0] w_presc_inc;
    logic [8:0]    w_sec_nx;   // {carry, tens, units}
    logic [8:0]    w_min_nx;   // {carry, tens, units}
    logic [7:0]    w_hr_nx;    // {tens, units}

    // Two-digit BCD increment modulo 60; MSB is the carry out of 59 -> 00.
    function automatic logic [8:0] inc_mod60(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd9) begin
            if (t == 4'd5) begin
                return {1'b1, 4'd0, 4'd0};
            end
            return {1'b0, t + 4'd1, 4'd0};
        end
        return {1'b0, t, u + 4'd1};
    endfunction

    // Two-digit BCD increment modulo 24.
    function automatic logic [7:0] inc_mod24(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) begin
            return 8'h00;
        end
        if (u == 4'd9) begin
            return {t + 4'd1, 4'd0};
        end
        return {t, u + 4'd1};
    endfunction

    assign w_mode_edge = btn_mode & ~r_mode_q;
    assign w_inc_edge  = btn_inc & ~r_inc_q;
    assign w_wrap      = (r_presc == c_presc_last);
    assign w_half      = (r_presc == c_presc_half);
    assign w_presc_inc = w_wrap ? '0 : r_presc + PW'(1);
    assign w_sec_nx    = inc_mod60(r_sec_t, r_sec_u);
    assign w_min_nx    = inc_mod60(r_min_t, r_min_u);
    assign w_hr_nx     = inc_mod24(r_hr_t, r_hr_u);

    always_comb begin
        w_state = r_state;
        w_presc = r_presc;
        w_blink = r_blink;
        w_hr_t  = r_hr_t;
        w_hr_u  = r_hr_u;
        w_min_t = r_min_t;
        w_min_u = r_min_u;
        w_sec_t = r_sec_t;
        w_sec_u = r_sec_u;
        w_tick  = 1'b0;
        w_blank = 6'b000000;

        case (r_state)
            ST_RUN: begin
                w_blink = 1'b0;
                if (en) begin
                    w_presc = w_presc_inc;
                    if (w_wrap) begin
                        w_tick             = 1'b1;
                        {w_sec_t, w_sec_u} = w_sec_nx[7:0];
                        if (w_sec_nx[8]) begin
                            {w_min_t, w_min_u} = w_min_nx[7:0];
                            if (w_min_nx[8]) begin
                                {w_hr_t, w_hr_u} = w_hr_nx;
                            end
                        end
                    end
                end
                if (w_mode_edge) begin
                    w_state = ST_SET_HR;
                    w_presc = '0;
                    w_blink = 1'b0;
                end
            end
            ST_SET_HR: begin
                // Prescaler free-runs in set states purely to pace the blink.
                w_presc = w_presc_inc;
                if (w_half || w_wrap) begin
                    w_blink = ~r_blink;
                end
                if (w_mode_edge) begin
                    w_state = ST_SET_MIN;
                end else if (w_inc_edge) begin
                    {w_hr_t, w_hr_u} = w_hr_nx;
                end
            end
            ST_SET_MIN: begin
                w_presc = w_presc_inc;
                if (w_half || w_wrap) begin
                    w_blink = ~r_blink;
                end
                if (w_mode_edge) begin
                    // Restart the second cleanly so the first tick is a full period away.
                    w_state = ST_RUN;
                    w_sec_t = 4'd0;
                    w_sec_u = 4'd0;
                    w_presc = '0;
                    w_blink = 1'b0;
                end else if (w_inc_edge) begin
                    // Minutes wrap without carrying into hours.
                    {w_min_t, w_min_u} = w_min_nx[7:0];
                end
            end
            default: begin
                w_state = ST_RUN;
                w_presc = '0;
                w_blink = 1'b0;
            end
        endcase

        // Mask follows the values being registered this edge so it stays
        // aligned with the mode output.
        if (w_blink) begin
            if (w_state == ST_SET_HR) begin
                w_blank = 6'b110000;
            end else if (w_state == ST_SET_MIN) begin
                w_blank = 6'b001100;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_presc  <= '0;
            r_blink  <= 1'b0;
            r_hr_t   <= 4'd0;
            r_hr_u   <= 4'd0;
            r_min_t  <= 4'd0;
            r_min_u  <= 4'd0;
            r_sec_t  <= 4'd0;
            r_sec_u  <= 4'd0;
            r_mode_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_blank  <= 6'b000000;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_presc  <= w_presc;
            r_blink  <= w_blink;
            r_hr_t   <= w_hr_t;
            r_hr_u   <= w_hr_u;
            r_min_t  <= w_min_t;
            r_min_u  <= w_min_u;
            r_sec_t  <= w_sec_t;
            r_sec_u  <= w_sec_u;
            r_mode_q <= btn_mode;
            r_inc_q  <= btn_inc;
            r_blank  <= w_blank;
            r_tick   <= w_tick;
        end
    end

    assign time_bcd   = {r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u};
    assign blank_mask = r_blank;
    assign mode       = r_state;
    assign sec_tick   = r_tick;

endmodule
`default_nettype wire
